mod_counter_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one mod-N counter (Mode5Counter family) between two requesters.

---
 rtl/mod_counter_arbiter_pkg.sv | 21 ++
 rtl/mod_n_counter.sv | 39 +++
 rtl/mod_counter_arbiter.sv | 120 ++++++++++++
 tb/tb_mod_counter_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter around one mod-N counter.
// Holds state codes, default sizing and the tie-break helper.
package mod_counter_arbiter_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned DEF_N   = 5;
  localparam int unsigned DEF_CW  = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN     = 2'b01;
  localparam logic [STATE_W-1:0] ST_RELEASE = 2'b10;

  // Winner among pending requests; a tie goes to whoever did not own last.
  function automatic logic pick_owner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    return r1;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Shared mod-N counter datapath: clear has priority, enable steps and wraps N-1 -> 0.
module mod_n_counter
  import mod_counter_arbiter_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign wrap  = (count_q == CW'(N - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mod_counter_arbiter.sv
// Round-robin arbiter lending one mod-N counter to two requesters for N counts per grant.
// A dropped request aborts the grant without a done pulse.
module mod_counter_arbiter
  import mod_counter_arbiter_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned CW = DEF_CW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  output logic               grant0,
  output logic               grant1,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic               done0,
  output logic               done1,
  output logic [STATE_W-1:0] state_out
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               grant0_q, grant0_d;
  logic               grant1_q, grant1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               owner_req;
  logic               cnt_en;
  logic               cnt_clr;
  logic               cnt_wrap;

  mod_n_counter #(
    .N  (N),
    .CW (CW)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (count),
    .wrap  (cnt_wrap)
  );

  assign owner_req = owner_q ? req1 : req0;

  // Next state, ownership bookkeeping and counter control.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_RUN;
          owner_d = pick_owner(req0, req1, last_q);
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else begin
          cnt_en  = 1'b1;
          cnt_clr = 1'b0;
          if (cnt_wrap) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    grant0_d = (state_d == ST_RUN) && !owner_d;
    grant1_d = (state_d == ST_RUN) && owner_d;
    done0_d  = (state_d == ST_RELEASE) && !owner_d;
    done1_d  = (state_d == ST_RELEASE) && owner_d;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign grant0    = grant0_q;
  assign grant1    = grant1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_mod_counter_arbiter.sv
// Bench for mod_counter_arbiter: N=5 and N=3 instances share stimulus and are checked
// against a per-instance behavioural model plus directed constant expectations.
module tb_mod_counter_arbiter;

  logic clock = 1'b0;
  logic reset;
  logic req0;
  logic req1;

  logic       g0a, g1a, d0a, d1a, ba;
  logic [2:0] ca;
  logic [1:0] sa;
  logic       g0b, g1b, d0b, d1b, bb;
  logic [1:0] cb;
  logic [1:0] sb;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 owning the counter, 2 release cycle.
  int ph[2];
  int own[2];
  int cnt[2];
  int last[2];
  int modn[2] = '{5, 3};

  always #5 clock = ~clock;

  mod_counter_arbiter #(.N(5), .CW(3)) u_a (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .grant0(g0a), .grant1(g1a), .busy(ba), .count(ca),
    .done0(d0a), .done1(d1a), .state_out(sa)
  );

  mod_counter_arbiter #(.N(3), .CW(2)) u_b (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .grant0(g0b), .grant1(g1b), .busy(bb), .count(cb),
    .done0(d0b), .done1(d1b), .state_out(sb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input logic r0, input logic r1, input logic rst);
    int want;
    if (rst) begin
      ph[i] = 0; own[i] = 0; cnt[i] = 0; last[i] = 1;
    end else if (ph[i] == 0) begin
      if (r0 || r1) begin
        own[i] = (r0 && r1) ? 1 - last[i] : (r1 ? 1 : 0);
        ph[i]  = 1;
        cnt[i] = 0;
      end
    end else if (ph[i] == 1) begin
      want = (own[i] == 1) ? int'(r1) : int'(r0);
      if (want == 0) begin
        ph[i] = 0; last[i] = own[i]; cnt[i] = 0;
      end else if (cnt[i] == modn[i] - 1) begin
        ph[i] = 2; cnt[i] = 0;
      end else begin
        cnt[i] = cnt[i] + 1;
      end
    end else begin
      last[i] = own[i];
      ph[i]   = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string p;
      logic [31:0] og0, og1, od0, od1, ob, oc, os;
      p = (i == 0) ? "a_" : "b_";
      if (i == 0) begin
        og0 = 32'(g0a); og1 = 32'(g1a); od0 = 32'(d0a); od1 = 32'(d1a);
        ob = 32'(ba); oc = 32'(ca); os = 32'(sa);
      end else begin
        og0 = 32'(g0b); og1 = 32'(g1b); od0 = 32'(d0b); od1 = 32'(d1b);
        ob = 32'(bb); oc = 32'(cb); os = 32'(sb);
      end
      chk({p, "grant0"}, og0, 32'(ph[i] == 1 && own[i] == 0));
      chk({p, "grant1"}, og1, 32'(ph[i] == 1 && own[i] == 1));
      chk({p, "done0"},  od0, 32'(ph[i] == 2 && own[i] == 0));
      chk({p, "done1"},  od1, 32'(ph[i] == 2 && own[i] == 1));
      chk({p, "busy"},   ob,  32'(ph[i] != 0));
      chk({p, "count"},  oc,  (ph[i] == 1) ? 32'(cnt[i]) : 32'd0);
      chk({p, "state"},  os,  32'(ph[i]));
      chk({p, "grant_onehot"}, og0 & og1, 32'd0);
    end
  endtask

  task automatic step(input logic r0, input logic r1, input logic rst);
    req0 = r0; req1 = r1; reset = rst;
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_step(i, r0, r1, rst);
    #1;
    check_all();
  endtask

  initial begin
    logic r0, r1, rst;

    // Reset held with both requests asserted.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("t1_state", 32'(sa), 32'd0);
    chk("t1_grant0", 32'(g0a), 32'd0);

    // Single requester 0 runs a full N=5 grant.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("t2_grant0", 32'(g0a), 32'd1);
      chk("t2_count", 32'(ca), 32'(k - 1));
    end
    step(1'b1, 1'b0, 1'b0);
    chk("t2_done0", 32'(d0a), 32'd1);
    chk("t2_release", 32'(sa), 32'd2);
    step(1'b1, 1'b0, 1'b0);
    chk("t2_idle", 32'(sa), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Held tie alternates requesters with a two-cycle gap.
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k == 1)  chk("t3_first_g0", 32'(g0a), 32'd1);
      if (k == 7)  chk("t3_gap_idle", 32'(ba), 32'd0);
      if (k == 8)  chk("t3_then_g1", 32'(g1a), 32'd1);
      if (k == 15) chk("t3_back_g0", 32'(g0a), 32'd1);
    end

    // Requester 1 aborts at count 2; next tie goes to requester 0.
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) step(1'b0, 1'b1, 1'b0);
    chk("t4_count2", 32'(ca), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_abort_g1", 32'(g1a), 32'd0);
    chk("t4_abort_cnt", 32'(ca), 32'd0);
    chk("t4_abort_st", 32'(sa), 32'd0);
    chk("t4_no_done1", 32'(d1a), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_tie_g0", 32'(g0a), 32'd1);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a grant.
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b0);
    chk("t5_count3", 32'(ca), 32'd3);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_rst_state", 32'(sa), 32'd0);
    chk("t5_rst_count", 32'(ca), 32'd0);
    chk("t5_rst_grant", 32'(g0a), 32'd0);
    chk("t5_rst_done", 32'(d0a), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_regrant", 32'(g0a), 32'd1);

    // N=3 instance with requester 1 alone.
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("t6_grant1", 32'(g1b), 32'd1);
      chk("t6_count", 32'(cb), 32'(k - 1));
    end
    step(1'b0, 1'b1, 1'b0);
    chk("t6_done1", 32'(d1b), 32'd1);

    // Random requests with sticky levels and occasional resets.
    r0 = 1'b0; r1 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) r0 = ~r0;
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      rst = ($urandom_range(0, 59) == 0);
      step(r0, r1, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
